// File: rtl/if_fetch_pkg.sv
`default_nettype none
// ----------------------------------------------------------------
// if_fetch_pkg : shared widths, reset PC and fetch FSM encoding
// Revision     : 1.0
// ----------------------------------------------------------------
package if_fetch_pkg;

  localparam int          c_ADDR_W     = 32;
  localparam int          c_INST_W     = 32;
  localparam logic [31:0] c_RESET_PC   = 32'hBFC0_0000;
  localparam logic [31:0] c_PC_STEP    = 32'd4;
  localparam logic [31:0] c_INST_NOP   = 32'h0000_0000;
  localparam logic [31:0] c_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_e;

  function automatic logic [c_ADDR_W-1:0] align_word(input logic [c_ADDR_W-1:0] i_a);
    return i_a & c_ALIGN_MASK;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_pc_sel.sv
`default_nettype none
// ----------------------------------------------------------------
// fetch_pc_sel : next-PC priority mux (branch > redirect > step)
// Revision     : 1.0
// ----------------------------------------------------------------
module fetch_pc_sel
  import if_fetch_pkg::*;
#(
  parameter logic [c_ADDR_W-1:0] PC_STEP = c_PC_STEP
) (
  input  logic [c_ADDR_W-1:0] i_pc,
  input  logic                i_branch_take,
  input  logic [c_ADDR_W-1:0] i_branch_addr,
  input  logic                i_redir_pend,
  input  logic [c_ADDR_W-1:0] i_redir_tgt,
  output logic [c_ADDR_W-1:0] o_next_pc
);

  always_comb begin
    o_next_pc = i_pc + PC_STEP;
    if (i_branch_take) begin
      o_next_pc = align_word(i_branch_addr);
    end else if (i_redir_pend) begin
      o_next_pc = align_word(i_redir_tgt);
    end
  end

endmodule
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ----------------------------------------------------------------
// if_fetch : PC owner, ROM request FSM and IF/ID pipeline register
// Revision : 1.0
// ----------------------------------------------------------------
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [c_ADDR_W-1:0] RESET_PC = c_RESET_PC,
  parameter logic [c_ADDR_W-1:0] PC_STEP  = c_PC_STEP
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_stall,
  input  logic                i_branch_flag,
  input  logic [c_ADDR_W-1:0] i_branch_addr,
  output logic                o_rom_en,
  output logic [c_ADDR_W-1:0] o_rom_addr,
  input  logic                i_rom_valid,
  input  logic [c_INST_W-1:0] i_rom_inst,
  output logic [c_ADDR_W-1:0] o_if_addr,
  output logic [c_INST_W-1:0] o_if_inst,
  output logic                o_if_valid
);

  fetch_state_e        r_state;
  logic [c_ADDR_W-1:0] r_pc;
  logic [c_INST_W-1:0] r_buf_inst;
  logic                r_redir_pend;
  logic [c_ADDR_W-1:0] r_redir_tgt;
  logic [c_ADDR_W-1:0] r_if_addr;
  logic [c_INST_W-1:0] r_if_inst;
  logic                r_if_valid;
  logic                r_rom_en;

  logic                w_branch_take;
  logic [c_ADDR_W-1:0] w_next_pc;

  assign w_branch_take = i_branch_flag & r_if_valid;

  fetch_pc_sel #(
    .PC_STEP (PC_STEP)
  ) u_pc_sel (
    .i_pc          (r_pc),
    .i_branch_take (w_branch_take),
    .i_branch_addr (i_branch_addr),
    .i_redir_pend  (r_redir_pend),
    .i_redir_tgt   (r_redir_tgt),
    .o_next_pc     (w_next_pc)
  );

  // The PC does not move while holding, so the buffered address is r_pc itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_BOOT;
      r_pc         <= RESET_PC;
      r_buf_inst   <= c_INST_NOP;
      r_redir_pend <= 1'b0;
      r_redir_tgt  <= '0;
      r_if_addr    <= '0;
      r_if_inst    <= c_INST_NOP;
      r_if_valid   <= 1'b0;
      r_rom_en     <= 1'b0;
    end else begin
      case (r_state)
        S_BOOT: begin
          r_state  <= S_FETCH;
          r_rom_en <= 1'b1;
        end
        S_FETCH: begin
          if (i_rom_valid && !i_stall) begin
            r_if_addr    <= r_pc;
            r_if_inst    <= i_rom_inst;
            r_if_valid   <= 1'b1;
            r_pc         <= w_next_pc;
            r_redir_pend <= 1'b0;
          end else if (i_rom_valid) begin
            r_buf_inst <= i_rom_inst;
            r_state    <= S_HOLD;
            r_rom_en   <= 1'b0;
          end else if (!i_stall) begin
            r_if_addr  <= '0;
            r_if_inst  <= c_INST_NOP;
            r_if_valid <= 1'b0;
            // Branch leaves decode before its delay slot arrives: remember the target.
            if (w_branch_take) begin
              r_redir_pend <= 1'b1;
              r_redir_tgt  <= i_branch_addr;
            end
          end
        end
        S_HOLD: begin
          if (!i_stall) begin
            r_if_addr    <= r_pc;
            r_if_inst    <= r_buf_inst;
            r_if_valid   <= 1'b1;
            r_pc         <= w_next_pc;
            r_redir_pend <= 1'b0;
            r_state      <= S_FETCH;
            r_rom_en     <= 1'b1;
          end
        end
        default: begin
          r_state  <= S_BOOT;
          r_rom_en <= 1'b0;
        end
      endcase
    end
  end

  assign o_rom_en   = r_rom_en;
  assign o_rom_addr = r_pc;
  assign o_if_addr  = r_if_addr;
  assign o_if_inst  = r_if_inst;
  assign o_if_valid = r_if_valid;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ----------------------------------------------------------------
// tb_if_fetch : directed bench with architectural fetch-order model
// Revision    : 1.0
// ----------------------------------------------------------------
module tb_if_fetch;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
  localparam logic [31:0] BR_PC  = 32'hBFC0_0008;
  localparam logic [31:0] BR_TGT = 32'hBFC0_0103;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_addr = 32'd0;
  logic        rom_valid = 1'b0;
  logic [31:0] rom_inst = 32'd0;
  logic        rom_en;
  logic [31:0] rom_addr;
  logic [31:0] if_addr;
  logic [31:0] if_inst;
  logic        if_valid;

  if_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_stall       (stall),
    .i_branch_flag (branch_flag),
    .i_branch_addr (branch_addr),
    .o_rom_en      (rom_en),
    .o_rom_addr    (rom_addr),
    .i_rom_valid   (rom_valid),
    .i_rom_inst    (rom_inst),
    .o_if_addr     (if_addr),
    .o_if_inst     (if_inst),
    .o_if_valid    (if_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = -1;

  bit          br_en       = 1'b0;
  logic [31:0] slow_addr   = 32'hFFFF_FFFF;
  int          stall_mode  = 0;
  bit          force_valid = 1'b0;

  logic [31:0] tr_addr  [64];
  logic [31:0] tr_inst  [64];
  logic [31:0] tr_raddr [64];
  logic        tr_valid [64];
  logic        tr_ren   [64];

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic bit is_br(input logic [31:0] a);
    return br_en && (a == BR_PC);
  endfunction

  function automatic bit stall_on(input int c);
    case (stall_mode)
      1:       return (c == 4) || (c == 5);
      2:       return (c >= 0) && ((c % 7 == 3) || (c % 7 == 4));
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Decode and ROM slave: inputs change only on the falling edge.
  bit          rs_busy = 1'b0;
  logic [31:0] rs_cur  = 32'd0;
  int          rs_cnt  = 0;
  always @(negedge clk) begin
    branch_flag = if_valid && is_br(if_addr);
    branch_addr = BR_TGT;
    stall       = stall_on(cyc);
    if (!rom_en) begin
      rs_busy   = 1'b0;
      rom_valid = 1'b0;
    end else begin
      if (!rs_busy || rom_addr != rs_cur) begin
        rs_busy = 1'b1;
        rs_cur  = rom_addr;
        rs_cnt  = (rom_addr == slow_addr) ? 3 : 0;
      end else if (rs_cnt > 0) begin
        rs_cnt--;
      end
      rom_valid = (rs_cnt == 0);
    end
    rom_inst = rom_word(rom_addr);
    if (force_valid) begin
      rom_valid = 1'b1;
      rom_inst  = 32'hDEAD_BEEF;
    end
  end

  // Architectural model: valid deliveries follow program order with one delay slot.
  logic [31:0] m_exp  = RST_PC;
  bit          m_slot = 1'b0;
  logic [31:0] m_tgt  = 32'd0;
  logic [31:0] p_addr = 32'd0;
  logic [31:0] p_inst = 32'd0;
  logic        p_valid = 1'b0;
  int          idle = 0;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      chk("rst_if_valid", 32'(if_valid), 32'd0);
      chk("rst_if_inst",  if_inst, 32'd0);
      chk("rst_if_addr",  if_addr, 32'd0);
      chk("rst_rom_en",   32'(rom_en), 32'd0);
      chk("rst_rom_addr", rom_addr, RST_PC);
      m_exp = RST_PC; m_slot = 1'b0; cyc = -1; idle = 0;
      p_addr = 32'd0; p_inst = 32'd0; p_valid = 1'b0;
    end else begin
      cyc++;
      if (cyc < 64) begin
        tr_addr[cyc] = if_addr;  tr_inst[cyc] = if_inst; tr_valid[cyc] = if_valid;
        tr_raddr[cyc] = rom_addr; tr_ren[cyc] = rom_en;
      end
      if (stall) begin
        chk("frozen_valid", 32'(if_valid), 32'(p_valid));
        chk("frozen_addr",  if_addr, p_addr);
        chk("frozen_inst",  if_inst, p_inst);
        idle++;
      end else if (if_valid) begin
        chk("seq_addr", if_addr, m_exp);
        chk("seq_inst", if_inst, rom_word(if_addr));
        m_exp  = m_slot ? m_tgt : if_addr + 32'd4;
        m_slot = is_br(if_addr);
        m_tgt  = BR_TGT & 32'hFFFF_FFFC;
        idle   = 0;
      end else begin
        chk("bubble_inst", if_inst, 32'd0);
        chk("bubble_addr", if_addr, 32'd0);
        idle++;
      end
      if (rom_en) chk("rom_align", 32'(rom_addr[1:0]), 32'd0);
      if (idle > 30) begin
        n_checks++; n_fail++;
        $display("FAIL no_progress: got %0d idle cycles required at most 30", idle);
        idle = 0;
      end
      p_addr = if_addr; p_inst = if_inst; p_valid = if_valid;
    end
  end

  task automatic do_reset(input int n);
    @(posedge clk); #3 rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk("boot_rom_en",   32'(rom_en), 32'd0);
    chk("boot_if_valid", 32'(if_valid), 32'd0);
    chk("boot_if_inst",  if_inst, 32'd0);
  endtask

  logic [31:0] exp_a [6];

  initial begin
    // A: reset then zero-wait ROM with branch 08 -> 103
    br_en = 1'b1; slow_addr = 32'hFFFF_FFFF; stall_mode = 0;
    do_reset(3);
    repeat (8) @(posedge clk); #2;
    chk("A_t0_rom_en",   32'(tr_ren[0]), 32'd1);
    chk("A_t0_rom_addr", tr_raddr[0], 32'hBFC0_0000);
    chk("A_t0_if_valid", 32'(tr_valid[0]), 32'd0);
    exp_a = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008,
              32'hBFC0_000C, 32'hBFC0_0100, 32'hBFC0_0104};
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("A_t%0d_addr", i + 1), tr_addr[i + 1], exp_a[i]);
      chk($sformatf("A_t%0d_valid", i + 1), 32'(tr_valid[i + 1]), 32'd1);
    end

    // B: delay-slot fetch of 0C waits 3 cycles
    slow_addr = 32'hBFC0_000C;
    do_reset(2);
    repeat (10) @(posedge clk); #2;
    chk("B_t3_addr", tr_addr[3], 32'hBFC0_0008);
    for (int i = 4; i < 7; i++) begin
      chk($sformatf("B_t%0d_valid", i), 32'(tr_valid[i]), 32'd0);
      chk($sformatf("B_t%0d_inst", i), tr_inst[i], 32'd0);
    end
    chk("B_t7_addr",  tr_addr[7], 32'hBFC0_000C);
    chk("B_t7_valid", 32'(tr_valid[7]), 32'd1);
    chk("B_t8_addr",  tr_addr[8], 32'hBFC0_0100);
    chk("B_t8_inst",  tr_inst[8], 32'h0100_FEFF);

    // C: 2-cycle stall while ROM returns BFC00010
    br_en = 1'b0; slow_addr = 32'hFFFF_FFFF; stall_mode = 1;
    do_reset(2);
    repeat (9) @(posedge clk); #2;
    chk("C_t4_rom_addr", tr_raddr[4], 32'hBFC0_0010);
    chk("C_t5_rom_en",   32'(tr_ren[5]), 32'd0);
    chk("C_t6_rom_en",   32'(tr_ren[6]), 32'd0);
    chk("C_t6_addr",     tr_addr[6], 32'hBFC0_000C);
    chk("C_t7_addr",     tr_addr[7], 32'hBFC0_0010);
    chk("C_t7_rom_en",   32'(tr_ren[7]), 32'd1);
    chk("C_t7_rom_addr", tr_raddr[7], 32'hBFC0_0014);

    // E: periodic stalls mixed with branch and slow delay slot
    br_en = 1'b1; slow_addr = 32'hBFC0_000C; stall_mode = 2;
    do_reset(2);
    repeat (45) @(posedge clk); #2;

    // D: asynchronous reset mid-fetch, late rom_valid during boot
    br_en = 1'b0; slow_addr = 32'hFFFF_FFFF; stall_mode = 0;
    do_reset(2);
    repeat (4) @(posedge clk);
    #3;
    chk("D_pre_valid", 32'(if_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("D_async_if_valid", 32'(if_valid), 32'd0);
    chk("D_async_if_inst",  if_inst, 32'd0);
    chk("D_async_if_addr",  if_addr, 32'd0);
    chk("D_async_rom_en",   32'(rom_en), 32'd0);
    chk("D_async_rom_addr", rom_addr, RST_PC);
    force_valid = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #2;
    force_valid = 1'b0;
    chk("D_t0_if_valid", 32'(tr_valid[0]), 32'd0);
    chk("D_t0_if_inst",  tr_inst[0], 32'd0);
    repeat (4) @(posedge clk); #2;
    chk("D_t1_addr", tr_addr[1], 32'hBFC0_0000);
    chk("D_t1_inst", tr_inst[1], 32'h0000_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL time_limit: got timeout required completion");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
